// File: rtl/envelope_mean_sift.sv
// Envelope-mean sifting stage. Upper and lower envelope streams arrive with
// independent valid levels; each side is buffered in a small skew FIFO, pairs
// are popped as soon as both heads exist, and the stage emits
// mean = (Emax+Emin)/2 and h = Xd - mean. The accumulated |mean| over a frame
// decides whether the frame qualifies as an IMF.
module envelope_mean_sift #(
  parameter int          FRAME_LEN  = 1024,
  parameter int          SKEW_DEPTH = 16,
  parameter logic [31:0] SD_THRESH  = 32'd4096
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               start,
  input  logic signed [15:0] Emax,
  input  logic signed [15:0] Xd,
  input  logic               max_start,
  input  logic signed [15:0] Emin,
  input  logic               min_start,
  output logic signed [15:0] h,
  output logic signed [15:0] mean,
  output logic               h_valid,
  output logic               frame_done,
  output logic               imf_flag,
  output logic [31:0]        sd_acc,
  output logic               err,
  output logic               busy
);
  localparam int PW  = $clog2(SKEW_DEPTH);
  localparam int PW1 = PW + 1;
  localparam int CW  = $clog2(FRAME_LEN + 1);
  localparam logic [PW:0]   DEPTH_W = PW1'(SKEW_DEPTH);
  localparam logic [CW-1:0] FRAME_W = CW'(FRAME_LEN);

  typedef enum logic [1:0] {IDLE, WAIT, RUN, DONE} state_t;
  state_t state_reg, state_next;

  logic          active, pop, flush, enter_done;
  logic [1:0]    side_start, cap, ovf, fifo_empty;
  logic [PW-1:0] wr_idx [2];
  logic [PW-1:0] rd_idx [2];

  // Upper side carries the envelope and the aligned delayed input together.
  logic [31:0] mem_max [SKEW_DEPTH];
  logic [15:0] mem_min [SKEW_DEPTH];

  logic               p_valid_reg, s_valid_reg, h_valid_reg;
  logic signed [15:0] p_emax_reg, p_emin_reg, p_xd_reg;
  logic signed [15:0] s_mean_reg, s_xd_reg;
  logic signed [15:0] h_reg, mean_reg;
  logic [CW-1:0]      out_cnt_reg;
  logic [31:0]        sd_acc_reg;
  logic               err_reg, imf_reg, frame_done_reg;

  logic signed [16:0] pair_sum, h_diff;
  logic signed [15:0] pair_mean, h_sat;
  logic [16:0]        mean_mag;
  logic [32:0]        acc_sum;

  assign active     = (state_reg == WAIT) || (state_reg == RUN);
  assign side_start = {min_start, max_start};
  // Pairing: both heads present; start and a pending error both freeze the FIFOs.
  assign pop = (state_reg == RUN) && !start && !err_reg && !fifo_empty[0] && !fifo_empty[1];

  for (genvar gi = 0; gi < 2; gi++) begin : g_side
    logic [PW:0]   wr_ptr_reg, rd_ptr_reg, occ;
    logic [CW-1:0] cnt_reg;
    logic          want, full;

    assign occ            = wr_ptr_reg - rd_ptr_reg;
    assign full           = (occ == DEPTH_W);
    assign fifo_empty[gi] = (wr_ptr_reg == rd_ptr_reg);
    assign want    = active && !start && !err_reg && side_start[gi] && (cnt_reg < FRAME_W);
    // A full FIFO still accepts a sample when a pop frees a slot on the same edge.
    assign cap[gi] = want && (!full || pop);
    assign ovf[gi] = want && full && !pop;
    assign wr_idx[gi] = wr_ptr_reg[PW-1:0];
    assign rd_idx[gi] = rd_ptr_reg[PW-1:0];

    // Pointer and per-side capture counter bookkeeping; start empties the side.
    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        cnt_reg    <= '0;
      end else if (start) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        cnt_reg    <= '0;
      end else begin
        if (cap[gi]) begin
          wr_ptr_reg <= wr_ptr_reg + 1'b1;
          cnt_reg    <= cnt_reg + 1'b1;
        end
        if (pop) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
    end
  end

  // Sample storage; contents are only meaningful between the pointers.
  always_ff @(posedge CLK) begin
    if (cap[0]) mem_max[wr_idx[0]] <= {Emax, Xd};
    if (cap[1]) mem_min[wr_idx[1]] <= Emin;
  end

  // Next-state logic; start restarts the frame from any state.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (start) state_next = WAIT;
      WAIT: begin
        if (start) state_next = WAIT;
        else if (max_start || min_start) state_next = RUN;
      end
      RUN: begin
        if (start) state_next = WAIT;
        else if (err_reg) state_next = DONE;
        else if (h_valid_reg && (out_cnt_reg == FRAME_W)) state_next = DONE;
      end
      DONE: state_next = start ? WAIT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign flush      = (state_next != RUN);
  assign enter_done = (state_next == DONE) && (state_reg != DONE);

  // Pair arithmetic: floor mean in 17 bits, saturated difference, |mean| sum.
  always_comb begin
    pair_sum  = 17'(p_emax_reg) + 17'(p_emin_reg);
    pair_mean = 16'(pair_sum >>> 1);
    h_diff    = 17'(s_xd_reg) - 17'(s_mean_reg);
    if (h_diff[16] != h_diff[15]) h_sat = h_diff[16] ? 16'sh8000 : 16'sh7FFF;
    else                          h_sat = h_diff[15:0];
    mean_mag = s_mean_reg[15] ? (17'd0 - 17'(s_mean_reg)) : {1'b0, s_mean_reg};
    acc_sum  = {1'b0, sd_acc_reg} + {16'd0, mean_mag};
  end

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Pair pipeline: popped heads -> mean stage -> output stage; leaving RUN flushes it.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      p_valid_reg <= 1'b0;
      p_emax_reg  <= '0;
      p_emin_reg  <= '0;
      p_xd_reg    <= '0;
      s_valid_reg <= 1'b0;
      s_mean_reg  <= '0;
      s_xd_reg    <= '0;
      h_valid_reg <= 1'b0;
      h_reg       <= '0;
      mean_reg    <= '0;
    end else begin
      p_valid_reg <= pop && !flush;
      if (pop) begin
        p_emax_reg <= mem_max[rd_idx[0]][31:16];
        p_xd_reg   <= mem_max[rd_idx[0]][15:0];
        p_emin_reg <= mem_min[rd_idx[1]];
      end
      s_valid_reg <= p_valid_reg && !flush;
      if (p_valid_reg) begin
        s_mean_reg <= pair_mean;
        s_xd_reg   <= p_xd_reg;
      end
      h_valid_reg <= s_valid_reg && !flush;
      if (s_valid_reg && !flush) begin
        h_reg    <= h_sat;
        mean_reg <= s_mean_reg;
      end
    end
  end

  // Per-frame status: output count, |mean| accumulator, error and stop flags.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      out_cnt_reg    <= '0;
      sd_acc_reg     <= '0;
      err_reg        <= 1'b0;
      imf_reg        <= 1'b0;
      frame_done_reg <= 1'b0;
    end else if (start) begin
      out_cnt_reg    <= '0;
      sd_acc_reg     <= '0;
      err_reg        <= 1'b0;
      imf_reg        <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      frame_done_reg <= enter_done;
      if (s_valid_reg && !flush) begin
        out_cnt_reg <= out_cnt_reg + 1'b1;
        sd_acc_reg  <= acc_sum[32] ? 32'hFFFF_FFFF : acc_sum[31:0];
      end
      if (|ovf) err_reg <= 1'b1;
      if (enter_done) imf_reg <= (sd_acc_reg < SD_THRESH) && !err_reg;
    end
  end

  assign h          = h_reg;
  assign mean       = mean_reg;
  assign h_valid    = h_valid_reg;
  assign frame_done = frame_done_reg;
  assign imf_flag   = imf_reg;
  assign sd_acc     = sd_acc_reg;
  assign err        = err_reg;
  assign busy       = (state_reg != IDLE);
endmodule

// File: tb/tb_envelope_mean_sift.sv
// Randomized frames against a pair-level reference model of the sifting stage.
module tb_envelope_mean_sift;
  localparam int          FL     = 8;
  localparam int          DEPTH  = 4;
  localparam logic [31:0] THRESH = 32'd2000;
  localparam int          L      = 48;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  logic start = 1'b0;
  logic max_start = 1'b0;
  logic min_start = 1'b0;
  logic signed [15:0] Emax = '0;
  logic signed [15:0] Xd = '0;
  logic signed [15:0] Emin = '0;
  logic signed [15:0] h, mean;
  logic h_valid, frame_done, imf_flag, err, busy;
  logic [31:0] sd_acc;

  int total = 0;
  int bad = 0;

  // Stimulus for the current frame, indexed by edge number after the start edge.
  logic mv [L];
  logic nv [L];
  logic signed [15:0] em [L];
  logic signed [15:0] en [L];
  logic signed [15:0] xv [L];

  // Expected results for the current frame.
  int exp_h[$];
  int exp_m[$];
  int exp_e[$];
  int exp_done;
  longint exp_sd;
  int exp_imf, exp_err;

  always #5 CLK = ~CLK;

  envelope_mean_sift #(.FRAME_LEN(FL), .SKEW_DEPTH(DEPTH), .SD_THRESH(THRESH)) dut (
    .CLK(CLK), .RST_N(RST_N), .start(start),
    .Emax(Emax), .Xd(Xd), .max_start(max_start),
    .Emin(Emin), .min_start(min_start),
    .h(h), .mean(mean), .h_valid(h_valid), .frame_done(frame_done),
    .imf_flag(imf_flag), .sd_acc(sd_acc), .err(err), .busy(busy)
  );

  task automatic check(input string tag, input longint obs, input longint expv);
    total++;
    if (obs != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic logic signed [15:0] gen_val(input int vmode);
    int v;
    case (vmode)
      1: begin
        case ($urandom_range(0, 5))
          0: v = 32767;
          1: v = -32768;
          2: v = -3;
          3: v = 0;
          4: v = 1;
          default: v = -1;
        endcase
      end
      2: v = int'($urandom_range(0, 400)) - 200;
      default: v = int'($urandom) % 32768;
    endcase
    return 16'(v);
  endfunction

  // mode 0 aligned, 1 fixed skew, 2 random gaps, 3 directed arithmetic corners
  task automatic build(input int mode, input int vmode, input int skew, input bit min_leads);
    for (int t = 0; t < L; t++) begin
      case (mode)
        1: begin
          mv[t] = min_leads ? (t >= skew) : 1'b1;
          nv[t] = min_leads ? 1'b1 : (t >= skew);
        end
        2: begin
          mv[t] = (t >= 32) || ($urandom_range(0, 3) != 0);
          nv[t] = (t >= 32) || ($urandom_range(0, 3) != 0);
        end
        default: begin
          mv[t] = 1'b1;
          nv[t] = 1'b1;
        end
      endcase
      if (mode == 3) begin
        em[t] = (t < 4) ? -16'sd32768 : -16'sd3;
        en[t] = (t < 4) ? -16'sd32768 : 16'sd0;
        xv[t] = (t < 4) ? 16'sd32767 : gen_val(2);
      end else begin
        em[t] = gen_val(vmode);
        en[t] = gen_val(vmode);
        xv[t] = gen_val(vmode);
      end
    end
  endtask

  // Reference: pair k leaves the stage 3 edges after its later capture; a side
  // holding DEPTH unpaired samples with no pair leaving drops the frame.
  task automatic model();
    int tmax[$];
    int tmin[$];
    int emv[$];
    int xdv[$];
    int env[$];
    int err_edge = -1;
    int np, s, m, d;
    longint sd = 0;
    exp_h.delete();
    exp_m.delete();
    exp_e.delete();
    for (int t = 0; t < L && err_edge < 0; t++) begin
      int popped_before = 0;
      bit pop_now = 0;
      np = (tmax.size() < tmin.size()) ? tmax.size() : tmin.size();
      for (int k = 0; k < np; k++) begin
        int later = (tmax[k] > tmin[k]) ? tmax[k] : tmin[k];
        if (later + 1 < t) popped_before++;
        else if (later + 1 == t) pop_now = 1;
      end
      if (mv[t] && tmax.size() < FL) begin
        if (tmax.size() - popped_before >= DEPTH && !pop_now) err_edge = t;
        else begin
          tmax.push_back(t);
          emv.push_back(int'(em[t]));
          xdv.push_back(int'(xv[t]));
        end
      end
      if (err_edge < 0 && nv[t] && tmin.size() < FL) begin
        if (tmin.size() - popped_before >= DEPTH && !pop_now) err_edge = t;
        else begin
          tmin.push_back(t);
          env.push_back(int'(en[t]));
        end
      end
    end
    np = (tmax.size() < tmin.size()) ? tmax.size() : tmin.size();
    for (int k = 0; k < np; k++) begin
      int e = ((tmax[k] > tmin[k]) ? tmax[k] : tmin[k]) + 3;
      if (err_edge >= 0 && e > err_edge) break;
      s = emv[k] + env[k];
      m = (s >= 0) ? s / 2 : -((1 - s) / 2);
      d = xdv[k] - m;
      if (d > 32767) d = 32767;
      if (d < -32768) d = -32768;
      exp_h.push_back(d);
      exp_m.push_back(m);
      exp_e.push_back(e);
      sd += (m < 0) ? -m : m;
    end
    exp_err = (err_edge >= 0);
    if (exp_err) exp_done = err_edge + 1;
    else if (np == FL) exp_done = exp_e[FL-1] + 1;
    else exp_done = -1;
    exp_sd = (sd > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : sd;
    exp_imf = (!exp_err && sd < longint'(THRESH)) ? 1 : 0;
  endtask

  task automatic junk_inputs();
    Emax = 16'($urandom);
    Emin = 16'($urandom);
    Xd   = 16'($urandom);
  endtask

  task automatic run_frame(input string name, input int mode, input int vmode,
                           input int skew, input bit min_leads);
    int obs_h[$];
    int obs_m[$];
    int obs_e[$];
    int done_first = -1;
    int done_cnt = 0;
    int n;
    build(mode, vmode, skew, min_leads);
    model();
    // Samples offered on the start cycle must be ignored.
    @(negedge CLK);
    start = 1'b1; max_start = 1'b1; min_start = 1'b1;
    junk_inputs();
    @(negedge CLK);
    start = 1'b0;
    check({name, "_busy_wait"}, busy, 1);
    check({name, "_sd_clr"}, sd_acc, 0);
    check({name, "_err_clr"}, err, 0);
    check({name, "_imf_clr"}, imf_flag, 0);
    for (int e = 0; e < L + 12; e++) begin
      if (e < L) begin
        max_start = mv[e]; min_start = nv[e];
        Emax = em[e]; Emin = en[e]; Xd = xv[e];
      end else begin
        max_start = 1'b0; min_start = 1'b0;
      end
      @(negedge CLK);
      if (h_valid) begin
        obs_h.push_back(int'(h));
        obs_m.push_back(int'(mean));
        obs_e.push_back(e);
      end
      if (frame_done) begin
        done_cnt++;
        if (done_first < 0) done_first = e;
      end
    end
    check({name, "_npairs"}, obs_h.size(), exp_h.size());
    n = (obs_h.size() < exp_h.size()) ? obs_h.size() : exp_h.size();
    for (int k = 0; k < n; k++) begin
      check($sformatf("%s_h%0d", name, k), obs_h[k], exp_h[k]);
      check($sformatf("%s_mean%0d", name, k), obs_m[k], exp_m[k]);
      check($sformatf("%s_edge%0d", name, k), obs_e[k], exp_e[k]);
    end
    check({name, "_done_edge"}, done_first, exp_done);
    check({name, "_done_pulses"}, done_cnt, 1);
    check({name, "_sd_acc"}, sd_acc, exp_sd);
    check({name, "_imf"}, imf_flag, exp_imf);
    check({name, "_err"}, err, exp_err);
    check({name, "_idle"}, busy, 0);
    $display("frame %s: pairs=%0d done_edge=%0d sd_acc=%0d imf=%0d err=%0d",
             name, obs_h.size(), done_first, sd_acc, imf_flag, err);
  endtask

  // Begin a frame and abandon it after k aligned cycles.
  task automatic run_partial(input string name, input int k);
    int seen = 0;
    @(negedge CLK);
    start = 1'b1; max_start = 1'b0; min_start = 1'b0;
    @(negedge CLK);
    start = 1'b0;
    for (int e = 0; e < k; e++) begin
      max_start = 1'b1; min_start = 1'b1;
      junk_inputs();
      @(negedge CLK);
      if (frame_done) seen++;
    end
    check({name, "_no_done"}, seen, 0);
    check({name, "_busy"}, busy, 1);
    $display("partial %s: cycles=%0d sd_acc=%0d", name, k, sd_acc);
  endtask

  task automatic check_zero(input string name);
    check({name, "_h"}, h, 0);
    check({name, "_mean"}, mean, 0);
    check({name, "_h_valid"}, h_valid, 0);
    check({name, "_frame_done"}, frame_done, 0);
    check({name, "_imf"}, imf_flag, 0);
    check({name, "_sd_acc"}, sd_acc, 0);
    check({name, "_err"}, err, 0);
    check({name, "_busy"}, busy, 0);
  endtask

  initial begin
    #2;
    check_zero("reset");
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    for (int i = 0; i < 3; i++) begin
      max_start = 1'b1; min_start = 1'b1;
      junk_inputs();
      @(negedge CLK);
      check("post_reset_busy", busy, 0);
      check("post_reset_h_valid", h_valid, 0);
    end
    max_start = 1'b0; min_start = 1'b0;

    run_frame("aligned", 0, 0, 0, 0);
    run_frame("aligned_small", 0, 2, 0, 0);
    run_frame("arith", 3, 0, 0, 0);
    run_frame("corners", 0, 1, 0, 0);
    run_frame("skew3", 1, 2, 3, 0);
    run_frame("skew3_minlead", 1, 0, 3, 1);
    run_frame("skew_ovf", 1, 0, 4, 0);
    run_frame("skew_ovf_minlead", 1, 2, 6, 1);
    for (int i = 0; i < 6; i++) run_frame($sformatf("gaps%0d", i), 2, i % 3, 0, 0);

    run_partial("restart", 5);
    run_frame("after_restart", 0, 2, 0, 0);

    run_partial("pre_reset", 6);
    @(negedge CLK);
    RST_N = 1'b0;
    #1;
    check_zero("mid_reset");
    @(negedge CLK);
    RST_N = 1'b1;
    for (int i = 0; i < 3; i++) begin
      max_start = 1'b1; min_start = 1'b1;
      junk_inputs();
      @(negedge CLK);
      check("after_reset_busy", busy, 0);
      check("after_reset_sd", sd_acc, 0);
    end
    max_start = 1'b0; min_start = 1'b0;
    run_frame("after_reset", 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation did not complete");
  end
endmodule
